// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register in front of the shifter
module uart_tx #(
    parameter logic [23:0] baud_rate  = 24'd4000000,
    parameter logic [27:0] clock_freq = 28'd50000000
) (
    input  logic       uart_clock,
    input  logic       uart_reset,
    input  logic [7:0] uart_d_in,
    input  logic       uart_valid,
    output logic       uart_ready,
    output logic       uart_d_out,
    output logic       uart_busy
);
    localparam logic [27:0] PULSE_DURATION = clock_freq / 28'(baud_rate);
    localparam logic [23:0] LAST_TICK = PULSE_DURATION[23:0] - 24'd1;

    if (PULSE_DURATION < 28'd2) begin : g_bad_rate
        $error("uart_tx: pulse_duration must be at least 2 clocks");
    end

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic        dout_q, dout_d;
    logic        accept, tick, load;

    // next-state: bit timing, shifting, and holding-register handoff (load wins over per-state updates)
    always_comb begin
        accept  = uart_valid && !full_q;
        tick    = timer_q == LAST_TICK;
        load    = 1'b0;
        state_d = state_q;
        timer_d = timer_q + 24'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        hold_d  = accept ? uart_d_in : hold_q;
        full_d  = full_q || accept;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                dout_d  = 1'b1;
                load    = full_q;
            end
            START_BIT: if (tick) begin
                state_d = DATA_BITS;
                timer_d = '0;
                idx_d   = '0;
                dout_d  = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA_BITS: if (tick) begin
                state_d = idx_q == 3'd7 ? STOP_BIT : DATA_BITS;
                timer_d = '0;
                idx_d   = idx_q + 3'd1;
                dout_d  = idx_q == 3'd7 ? 1'b1 : shift_q[0];
                shift_d = shift_q >> 1;
            end
            STOP_BIT: if (tick) begin
                state_d = IDLE;
                timer_d = '0;
                dout_d  = 1'b1;
                load    = full_q;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                dout_d  = 1'b1;
            end
        endcase
        if (load) begin
            state_d = START_BIT;
            timer_d = '0;
            shift_d = hold_q;
            full_d  = 1'b0;
            dout_d  = 1'b0;
        end
    end

    // state register with synchronous reset; reset discards any pending byte
    always_ff @(posedge uart_clock) begin
        if (uart_reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            dout_q  <= dout_d;
        end
    end

    assign uart_ready = !full_q;
    assign uart_busy  = (state_q != IDLE) || full_q;
    assign uart_d_out = dout_q;
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: baud_rate, 24'd4000000, serial bit rate in bits/s.
REQ-002 Parameter: clock_freq, 28'd50000000, uart_clock frequency in Hz.
REQ-003 Port: uart_clock  input  1  single clock; all logic on rising edge.
REQ-004 Port: uart_reset  input  1  synchronous, active-high reset.
REQ-005 Port: uart_d_in  input  8  byte to transmit; sampled only on accept.
REQ-006 Port: uart_valid  input  1  requester has a byte on uart_d_in.
REQ-007 Port: uart_ready  output  1  block can accept a byte this cycle.
REQ-008 Port: uart_d_out  output  1  serial line, registered, idles high.
REQ-009 Port: uart_busy  output  1  high while a frame is in flight or a byte is pending.

Function
REQ-010 The block SHALL define pulse_duration = clock_freq / baud_rate as an integer division truncated toward zero; defaults give 12 clocks per bit.
REQ-011 pulse_duration below 2 SHALL be flagged as a design-time error.
REQ-012 The bit timer SHALL be 24 bits wide and count 0..pulse_duration-1 per bit.
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); 10 bits, 10*pulse_duration clocks.
REQ-014 A one-byte holding register SHALL decouple the requester from the shifter.
REQ-015 uart_ready SHALL equal NOT holding-register-full, combinationally.
REQ-016 Accept SHALL occur on a rising edge where uart_valid=1 and uart_ready=1; the byte is latched into the holding register at that edge.
REQ-017 uart_valid with uart_ready=0 SHALL be ignored: no latch and no state change.
REQ-018 FSM states SHALL be Idle, Start_Bit, Data_Bits, Stop_Bit.
REQ-019 Idle, holding register full: at the next edge, load the shifter from the holding register, clear the holding register, enter Start_Bit, drive uart_d_out=0 and clear the bit timer.
REQ-020 Single-byte latency: accept at edge N, uart_d_out falls after edge N+1.
REQ-021 Start_Bit: hold 0 for pulse_duration clocks, then enter Data_Bits and drive bit 0.
REQ-022 Data_Bits: each bit SHALL last pulse_duration clocks; a 3-bit index counts 0..7; after bit 7 the block enters Stop_Bit and drives 1.
REQ-023 Stop_Bit: hold 1 for pulse_duration clocks.
REQ-024 At the end of Stop_Bit with the holding register full, the block SHALL go directly to Start_Bit and load the next byte, leaving no idle gap.
REQ-025 At the end of Stop_Bit with the holding register empty, the block SHALL enter Idle with uart_d_out=1.
REQ-026 A new byte SHALL be accepted during any state when the holding register is empty, including the transfer edge, without corrupting the frame on the line.
REQ-027 uart_busy SHALL be 1 when state is not Idle or the holding register is full, else 0.
REQ-028 An illegal state SHALL recover to Idle with uart_d_out=1 on the next edge.

Reset
REQ-029 While uart_reset=1 at a rising edge: state=Idle, uart_d_out=1, holding register empty (uart_ready=1), uart_busy=0, bit timer=0, bit index=0, shifter=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: line high from the next edge; the pending byte is discarded.
REQ-031 uart_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-032 Defaults, send 0xA5 -> 12 clocks low, then bits 1,0,1,0,0,1,0,1 at 12 clocks each, 12 clocks high, Idle; 120 clocks from first 0 to Idle.
REQ-033 Back-to-back 0x00 then 0xFF, uart_valid held high -> second start bit immediately follows the first stop bit; 240 line clocks total; uart_ready low exactly while a byte is pending.
REQ-034 uart_valid held high for 300 clocks with uart_d_in=0x3C -> one frame per accept, no duplicated or dropped bytes; frame count equals accept count.
REQ-035 Reset pulsed at clock 50 of a 0x55 frame -> uart_d_out=1, uart_busy=0, uart_ready=1 the edge after; the next byte 0x81 transmits correctly.
REQ-036 Override clock_freq=16, baud_rate=4 -> 4 clocks per bit, 40-clock frame for 0xC3; bench decoder recovers 0xC3.
